xoodoo_perm_dom_nshare: RTL and testbench
=========================================

// Module: xoodoo_perm_dom_nshare
// PURPOSE
//  Parametrised DOM-masked Xoodoo[NROUNDS] permutation: NSHARES-share state registers, round sequencer
//  and fresh-randomness handshake in one block. Successor to the fixed 2-share, fixed-12-round permutation;
//  sits under CryptoCore_SCA and is fed by the PRNG over a valid/ready rdi channel.
//  One round = 2 phases: NL (theta, rho-west, iota, DOM chi products registered) then CMP (compress, rho-east).
// PARAMETERS
//  NSHARES  2   number of Boolean shares, >=2 (masking order NSHARES-1)
//  NROUNDS  12  rounds executed, 1..12; uses the last NROUNDS Xoodoo round constants
//  RDI_W    384*NSHARES*(NSHARES-1)/2  fresh-random bits consumed per round (derived, do not override)
// PORTS
//  clk_i         in   1            clock; all logic rising-edge
//  rst_ni        in   1            synchronous reset, active low
//  load_i        in   1            write state_i into share registers (IDLE only)
//  state_i       in   384*NSHARES  share s at [384*s +: 384]; lane (x,y) at [32*(4*y+x) +: 32]
//  start_i       in   1            start permutation (IDLE only)
//  abort_i       in   1            abandon run, clear shares
//  rdi_i         in   RDI_W        fresh randomness; pair (i<j) r_ij at index k of pairs in (i,j) lexicographic order, [384*k +: 384]
//  rdi_valid_i   in   1            rdi_i valid
//  rdi_ready_o   out  1            block takes rdi_i this cycle if rdi_valid_i
//  busy_o        out  1            permutation in progress
//  done_o        out  1            1-cycle pulse: state_o holds permuted shares
//  state_o       out  384*NSHARES  share registers, direct
// BEHAVIOUR
//  Reset (rst_ni=0 at edge): FSM=IDLE, round cnt=0, shares=0, DOM product regs=0; rdi_ready_o=0, busy_o=0,
//   done_o=0, state_o=0. Reset overrides everything, including mid-run (no done_o).
//  FSM: IDLE -start_i-> NL(r=0); NL -rdi_valid_i-> CMP; NL -!rdi_valid_i-> NL (stall, nothing written);
//   CMP -> NL(r+1) if r<NROUNDS-1, else IDLE with done_o=1 next cycle. Any state -abort_i-> IDLE, shares=0.
//  Priority per edge: reset > abort_i > load_i > start_i. load_i and start_i same cycle in IDLE: load done, start dropped.
//  start_i/load_i while busy: ignored. abort_i in IDLE: clears shares.
//  busy_o = (FSM!=IDLE); rdi_ready_o = (FSM==NL); both decoded from registers only, never from rdi_valid_i.
//  Latency: start_i sampled at edge t -> done_o high in cycle t+2*NROUNDS+1 (t+25 for 12) with zero stalls;
//   each NL cycle with rdi_valid_i=0 adds exactly 1 cycle. Exactly RDI_W bits consumed per round.
//  NL phase, per share s (combinational from share regs): theta (P=A0^A1^A2; E=P<<<(1,5)^P<<<(1,14)),
//   rho-west (A1<<<(1,0), A2 lanes z-rot 11), iota: round constant XORed into lane (0,0) of share 0 only.
//   Chi a^=(~b)&c, lane-parallel; complement applied to share 0 only. Registered terms:
//   same-domain a_s^(b_s&c_s) form, cross-domain b_i&c_j ^ r_ij (i!=j, r_ji=r_ij). All in same edge.
//  CMP phase: share s = sum of its registered terms; then rho-east (A1 z-rot 1, A2 <<<(2,8)); write shares.
//  Round constants (r=-11..0): 058 038 3C0 0D0 120 014 060 02C 380 0F0 1A0 012; NROUNDS uses last NROUNDS.
//  Unmasked value XOR(shares) after done_o equals Xoodoo[NROUNDS](XOR of loaded shares), for any rdi.
//  state_o only changes on load, CMP write, abort, reset; stable between done_o and next start/load.
//  No share ever combined with another share combinationally before a register (DOM glitch rule).
// TESTING
//  Reset: rst_ni=0 2 cycles mid-run (round 4) -> busy_o=0, rdi_ready_o=0, state_o=0, no done_o.
//  NSHARES=2, load all-zero unmasked (share1=random R, share0=R), rdi_valid_i=1 -> done_o at t+25,
//   share0^share1 = Xoodoo[12](0) golden from software model; repeat with rdi=0 -> same unmasked result.
//  Stall: rdi_valid_i=0 for 3 cycles in round 5 NL -> done_o at t+28, result unchanged, rdi consumed 12 times.
//  Priority: load_i+start_i same cycle -> loaded, busy_o=0; start_i during run -> ignored, done at t+25 of first.
//  Abort at round 7 CMP -> next cycle IDLE, shares=0, no done_o; fresh start then completes normally.
//  NSHARES=3, NROUNDS=6: RDI_W=1152, done at t+13, unmasked result = Xoodoo[6] golden; random rdi each round.

Source files
------------

// File: rtl/xoodoo_perm_dom_nshare.sv
// DOM-masked Xoodoo[NROUNDS] permutation over NSHARES Boolean shares: share registers,
// a two-phase round sequencer (NL then CMP) and the fresh-randomness intake.
module xoodoo_perm_dom_nshare #(
    parameter int NSHARES = 2,
    parameter int NROUNDS = 12,
    parameter int RDI_W   = 384 * NSHARES * (NSHARES - 1) / 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic [384*NSHARES-1:0] state_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [RDI_W-1:0]       rdi_i,
    input  logic                   rdi_valid_i,
    output logic                   rdi_ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [384*NSHARES-1:0] state_o
);

    localparam int NCROSS = NSHARES * (NSHARES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NL   = 2'd1,
        S_CMP  = 2'd2
    } fsm_e;

    fsm_e         state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;
    logic         do_load, do_cmp, do_clr, do_capture;

    logic [383:0] share_q  [NSHARES];
    logic [383:0] same_q   [NSHARES];
    logic [383:0] cross_q  [NCROSS];

    logic [383:0] nl_st    [NSHARES];
    logic [383:0] b_sh     [NSHARES];
    logic [383:0] c_sh     [NSHARES];
    logic [383:0] same_d   [NSHARES];
    logic [383:0] cross_d  [NCROSS];
    logic [383:0] cmp_val  [NSHARES];
    logic [383:0] acc;
    logic [31:0]  rc_val;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] round_const(input int idx);
        logic [31:0] v;
        case (idx)
            0:       v = 32'h058;
            1:       v = 32'h038;
            2:       v = 32'h3C0;
            3:       v = 32'h0D0;
            4:       v = 32'h120;
            5:       v = 32'h014;
            6:       v = 32'h060;
            7:       v = 32'h02C;
            8:       v = 32'h380;
            9:       v = 32'h0F0;
            10:      v = 32'h1A0;
            default: v = 32'h012;
        endcase
        return v;
    endfunction

    // Linear part of a round; safe to apply to each share on its own.
    function automatic logic [383:0] theta_rho_west(input logic [383:0] a);
        logic [31:0]  p [4];
        logic [31:0]  e [4];
        logic [383:0] t;
        logic [383:0] o;
        for (int x = 0; x < 4; x++)
            p[x] = a[32*x +: 32] ^ a[32*(4+x) +: 32] ^ a[32*(8+x) +: 32];
        for (int x = 0; x < 4; x++)
            e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                t[32*(4*y+x) +: 32] = a[32*(4*y+x) +: 32] ^ e[x];
        for (int x = 0; x < 4; x++) begin
            o[32*x +: 32]     = t[32*x +: 32];
            o[32*(4+x) +: 32] = t[32*(4+(x+3)%4) +: 32];
            o[32*(8+x) +: 32] = rotl(t[32*(8+x) +: 32], 11);
        end
        return o;
    endfunction

    function automatic logic [383:0] rho_east(input logic [383:0] a);
        logic [383:0] o;
        for (int x = 0; x < 4; x++) begin
            o[32*x +: 32]     = a[32*x +: 32];
            o[32*(4+x) +: 32] = rotl(a[32*(4+x) +: 32], 1);
            o[32*(8+x) +: 32] = rotl(a[32*(8+(x+2)%4) +: 32], 8);
        end
        return o;
    endfunction

    // Plane y of the result holds plane (y+k) mod 3 of the input: chi operands b and c.
    function automatic logic [383:0] plane_shift(input logic [383:0] a, input int k);
        logic [383:0] o;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                o[32*(4*y+x) +: 32] = a[32*(4*((y+k)%3)+x) +: 32];
        return o;
    endfunction

    function automatic int pair_idx(input int i, input int j);
        return i * (2*NSHARES - i - 1) / 2 + (j - i - 1);
    endfunction

    function automatic int cross_idx(input int i, input int j);
        return i * (NSHARES - 1) + ((j < i) ? j : j - 1);
    endfunction

    assign rc_val = round_const(12 - NROUNDS + int'(rnd_q));

    // NL phase. Cross-domain products b_i&c_j are masked by r_ij before they reach
    // a register, so no two shares meet in combinational logic unmasked.
    always_comb begin
        for (int s = 0; s < NSHARES; s++) begin
            nl_st[s] = theta_rho_west(share_q[s]);
        end
        nl_st[0][31:0] = nl_st[0][31:0] ^ rc_val;
        for (int s = 0; s < NSHARES; s++) begin
            b_sh[s]   = plane_shift(nl_st[s], 1) ^ ((s == 0) ? {384{1'b1}} : 384'd0);
            c_sh[s]   = plane_shift(nl_st[s], 2);
            same_d[s] = nl_st[s] ^ (b_sh[s] & c_sh[s]);
        end
        for (int k = 0; k < NCROSS; k++) begin
            cross_d[k] = '0;
        end
        for (int i = 0; i < NSHARES; i++) begin
            for (int j = 0; j < NSHARES; j++) begin
                if (i != j) begin
                    cross_d[cross_idx(i, j)] = (b_sh[i] & c_sh[j])
                        ^ rdi_i[384*pair_idx((i < j) ? i : j, (i < j) ? j : i) +: 384];
                end
            end
        end
    end

    // CMP phase: each share folds only its own registered terms.
    always_comb begin
        acc = '0;
        for (int s = 0; s < NSHARES; s++) begin
            acc = same_q[s];
            for (int j = 0; j < NSHARES; j++) begin
                if (j != s) acc = acc ^ cross_q[cross_idx(s, j)];
            end
            cmp_val[s] = rho_east(acc);
        end
    end

    // Handshake: rdi_i is consumed on a rising edge where rdi_valid_i && rdi_ready_o;
    // rdi_ready_o is a pure decode of the state register and never looks at rdi_valid_i.
    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        done_d     = 1'b0;
        do_load    = 1'b0;
        do_cmp     = 1'b0;
        do_clr     = 1'b0;
        do_capture = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            rnd_d   = '0;
            do_clr  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_i) begin
                        do_load = 1'b1;
                    end else if (start_i) begin
                        state_d = S_NL;
                        rnd_d   = '0;
                    end
                end
                S_NL: begin
                    if (rdi_valid_i) begin
                        do_capture = 1'b1;
                        state_d    = S_CMP;
                    end
                end
                S_CMP: begin
                    do_cmp = 1'b1;
                    if (rnd_q == 4'(NROUNDS - 1)) begin
                        state_d = S_IDLE;
                        rnd_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_NL;
                        rnd_d   = rnd_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rnd_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            done_q  <= 1'b0;
            for (int s = 0; s < NSHARES; s++) begin
                share_q[s] <= '0;
                same_q[s]  <= '0;
            end
            for (int k = 0; k < NCROSS; k++) begin
                cross_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
            for (int s = 0; s < NSHARES; s++) begin
                if (do_clr)          share_q[s] <= '0;
                else if (do_load)    share_q[s] <= state_i[384*s +: 384];
                else if (do_cmp)     share_q[s] <= cmp_val[s];
                if (do_clr)          same_q[s]  <= '0;
                else if (do_capture) same_q[s]  <= same_d[s];
            end
            for (int k = 0; k < NCROSS; k++) begin
                if (do_clr)          cross_q[k] <= '0;
                else if (do_capture) cross_q[k] <= cross_d[k];
            end
        end
    end

    always_comb begin
        state_o = '0;
        for (int s = 0; s < NSHARES; s++) begin
            state_o[384*s +: 384] = share_q[s];
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign rdi_ready_o = (state_q == S_NL);
    assign done_o      = done_q;

endmodule

// File: tb/tb_xoodoo_perm_dom_nshare.sv
// Bench for xoodoo_perm_dom_nshare: a 2-share/12-round and a 3-share/6-round instance
// checked against an unmasked Xoodoo reference model.
module tb_xoodoo_perm_dom_nshare;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         load2, start2, abort2, rdv2, rdy2, busy2, done2;
    logic [767:0] sti2, st2;
    logic [383:0] rdi2;

    logic          load3, start3, abort3, rdv3, rdy3, busy3, done3;
    logic [1151:0] sti3, st3;
    logic [1151:0] rdi3;

    xoodoo_perm_dom_nshare #(.NSHARES(2), .NROUNDS(12)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load2), .state_i(sti2), .start_i(start2),
        .abort_i(abort2), .rdi_i(rdi2), .rdi_valid_i(rdv2), .rdi_ready_o(rdy2),
        .busy_o(busy2), .done_o(done2), .state_o(st2)
    );

    xoodoo_perm_dom_nshare #(.NSHARES(3), .NROUNDS(6)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load3), .state_i(sti3), .start_i(start3),
        .abort_i(abort3), .rdi_i(rdi3), .rdi_valid_i(rdv3), .rdi_ready_o(rdy3),
        .busy_o(busy3), .done_o(done3), .state_o(st3)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] rc_tab [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                 32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

    typedef struct {
        logic [383:0] unm;
        logic [383:0] mask;
        int           rdi_mode;
        int           stall_n;
        logic [383:0] exp_res;
        int           exp_lat;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [383:0] rand384();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Unmasked Xoodoo on a 3x4 lane array, rounds indexed by their constant.
    function automatic logic [383:0] xoodoo_ref(input logic [383:0] s, input int nr);
        logic [31:0]  a [3][4];
        logic [31:0]  b [3][4];
        logic [31:0]  p [4];
        logic [31:0]  t [4];
        logic [383:0] o;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] = s[32*(4*y+x) +: 32];
        for (int r = 12 - nr; r < 12; r++) begin
            for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++)
                    a[y][x] = a[y][x] ^ rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
            t = a[1];
            for (int x = 0; x < 4; x++) begin
                a[1][x] = t[(x+3)%4];
                a[2][x] = rol(a[2][x], 11);
            end
            a[0][0] = a[0][0] ^ rc_tab[r];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) b[y][x] = ~a[(y+1)%3][x] & a[(y+2)%3][x];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ b[y][x];
            t = a[2];
            for (int x = 0; x < 4; x++) begin
                a[1][x] = rol(a[1][x], 1);
                a[2][x] = rol(t[(x+2)%4], 8);
            end
        end
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) o[32*(4*y+x) +: 32] = a[y][x];
        return o;
    endfunction

    task automatic chk(input string name, input logic [383:0] got, input logic [383:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Loads share1=mask, share0=unm^mask, then pulses start; returns at the negedge after the start edge.
    task automatic load_start2(input logic [383:0] unm, input logic [383:0] mask);
        @(negedge clk);
        load2 = 1'b1;
        sti2  = {mask, unm ^ mask};
        @(negedge clk);
        load2  = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    // Feeds rdi until done2; lat counts edges after the start edge. Stalls round 5 NL for stall_n
    // cycles; at lat==poke_at it drives start2+load2 to show they are ignored while busy.
    task automatic drive2(input int rdi_mode, input int stall_n, input int poke_at,
                          output int lat, output int takes);
        int stall_left;
        stall_left = stall_n;
        lat   = 0;
        takes = 0;
        while (done2 !== 1'b1 && lat < 200) begin
            start2 = (lat == poke_at);
            load2  = (lat == poke_at);
            if (lat == poke_at) sti2 = ~sti2;
            rdv2 = 1'b1;
            if (rdy2 && takes == 5 && stall_left > 0) begin
                rdv2 = 1'b0;
                stall_left--;
            end
            rdi2 = (rdi_mode == 0) ? 384'd0 : rand384();
            if (rdy2 && rdv2) takes++;
            @(negedge clk);
            lat++;
        end
        start2 = 1'b0;
        load2  = 1'b0;
        rdv2   = 1'b0;
    endtask

    task automatic load_start3(input logic [383:0] unm, input logic [383:0] m1, input logic [383:0] m2);
        @(negedge clk);
        load3 = 1'b1;
        sti3  = {m2, m1, unm ^ m1 ^ m2};
        @(negedge clk);
        load3  = 1'b0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
    endtask

    task automatic drive3(output int lat, output int takes);
        lat   = 0;
        takes = 0;
        while (done3 !== 1'b1 && lat < 200) begin
            rdv3 = 1'b1;
            rdi3 = {rand384(), rand384(), rand384()};
            if (rdy3) takes++;
            @(negedge clk);
            lat++;
        end
        rdv3 = 1'b0;
    endtask

    initial begin
        int           lat, takes, seen;
        logic [383:0] a, m, m2;

        rst_n = 1'b0;
        load2 = 1'b0; start2 = 1'b0; abort2 = 1'b0; rdv2 = 1'b0; sti2 = '0; rdi2 = '0;
        load3 = 1'b0; start3 = 1'b0; abort3 = 1'b0; rdv3 = 1'b0; sti3 = '0; rdi3 = '0;

        vecs[0] = '{384'd0,      rand384(), 1, 0, 384'd0, 0};
        vecs[1] = '{384'd0,      rand384(), 0, 0, 384'd0, 0};
        vecs[2] = '{384'd0,      rand384(), 1, 3, 384'd0, 0};
        vecs[3] = '{rand384(),   rand384(), 1, 0, 384'd0, 0};
        vecs[4] = '{rand384(),   384'd0,    1, 0, 384'd0, 0};
        vecs[5] = '{{384{1'b1}}, rand384(), 1, 1, 384'd0, 0};
        for (int i = 0; i < 6; i++) begin
            vecs[i].exp_res = xoodoo_ref(vecs[i].unm, 12);
            // done_o in cycle t+2*NROUNDS+1 (+1 per stall), counting the start cycle as t
            vecs[i].exp_lat = 25 + vecs[i].stall_n;
        end

        repeat (3) @(negedge clk);
        chk_int("rst_busy2", int'(busy2), 0);
        chk_int("rst_ready2", int'(rdy2), 0);
        chk_int("rst_done2", int'(done2), 0);
        chk("rst_st2_sh0", st2[383:0], 384'd0);
        chk("rst_st2_sh1", st2[767:384], 384'd0);
        chk_int("rst_busy3", int'(busy3), 0);
        chk_int("rst_st3_nonzero", int'(|st3), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            load_start2(vecs[i].unm, vecs[i].mask);
            drive2(vecs[i].rdi_mode, vecs[i].stall_n, -1, lat, takes);
            chk_int($sformatf("v%0d_latency", i), lat + 1, vecs[i].exp_lat);
            chk($sformatf("v%0d_result", i), st2[383:0] ^ st2[767:384], vecs[i].exp_res);
            chk_int($sformatf("v%0d_rdi_takes", i), takes, 12);
            @(negedge clk);
            chk_int($sformatf("v%0d_done_pulse", i), int'(done2), 0);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_hold", i), st2[383:0] ^ st2[767:384], vecs[i].exp_res);
        end

        // Reset held 2 cycles in round 4 NL
        load_start2(rand384(), rand384());
        takes = 0;
        lat   = 0;
        while (!(takes == 4 && rdy2) && lat < 100) begin
            rdv2 = 1'b1;
            rdi2 = rand384();
            if (rdy2) takes++;
            @(negedge clk);
            lat++;
        end
        chk_int("midrst_reach_round4", takes, 4);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_int("midrst_busy", int'(busy2), 0);
        chk_int("midrst_ready", int'(rdy2), 0);
        chk("midrst_sh0", st2[383:0], 384'd0);
        chk("midrst_sh1", st2[767:384], 384'd0);
        seen = 0;
        rdv2 = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done2) seen = 1;
        end
        rdv2 = 1'b0;
        chk_int("midrst_no_done", seen, 0);

        // load_i and start_i together: load wins, no run
        a = rand384();
        m = rand384();
        @(negedge clk);
        load2  = 1'b1;
        start2 = 1'b1;
        sti2   = {m, a ^ m};
        @(negedge clk);
        load2  = 1'b0;
        start2 = 1'b0;
        chk_int("ldst_busy", int'(busy2), 0);
        chk("ldst_sh0", st2[383:0], a ^ m);
        chk("ldst_sh1", st2[767:384], m);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        drive2(1, 0, 5, lat, takes);
        chk_int("busy_poke_latency", lat + 1, 25);
        chk("busy_poke_result", st2[383:0] ^ st2[767:384], xoodoo_ref(a, 12));

        // Abort in round 7 CMP, then a clean run
        load_start2(rand384(), rand384());
        takes = 0;
        lat   = 0;
        while (!(takes == 8 && !rdy2 && busy2) && lat < 100) begin
            rdv2 = 1'b1;
            rdi2 = rand384();
            if (rdy2) takes++;
            @(negedge clk);
            lat++;
        end
        rdv2   = 1'b0;
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        chk_int("abort_busy", int'(busy2), 0);
        chk("abort_sh0", st2[383:0], 384'd0);
        chk("abort_sh1", st2[767:384], 384'd0);
        seen = 0;
        rdv2 = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done2) seen = 1;
        end
        rdv2 = 1'b0;
        chk_int("abort_no_done", seen, 0);
        a = rand384();
        load_start2(a, rand384());
        drive2(1, 0, -1, lat, takes);
        chk_int("post_abort_latency", lat + 1, 25);
        chk("post_abort_result", st2[383:0] ^ st2[767:384], xoodoo_ref(a, 12));

        // Abort in IDLE, and abort beating a same-cycle load
        @(negedge clk);
        load2 = 1'b1;
        sti2  = {rand384(), rand384()};
        @(negedge clk);
        load2  = 1'b0;
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        chk("idle_abort_clear", st2[383:0] | st2[767:384], 384'd0);
        load2  = 1'b1;
        abort2 = 1'b1;
        sti2   = {rand384(), rand384()};
        @(negedge clk);
        load2  = 1'b0;
        abort2 = 1'b0;
        chk("abort_over_load", st2[383:0] | st2[767:384], 384'd0);

        // Three shares, six rounds
        for (int i = 0; i < 2; i++) begin
            a  = (i == 0) ? 384'd0 : rand384();
            m  = rand384();
            m2 = rand384();
            load_start3(a, m, m2);
            drive3(lat, takes);
            chk_int($sformatf("ns3_%0d_latency", i), lat + 1, 13);
            chk_int($sformatf("ns3_%0d_rdi_takes", i), takes, 6);
            chk($sformatf("ns3_%0d_result", i), st3[383:0] ^ st3[767:384] ^ st3[1151:768],
                xoodoo_ref(a, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
